// File: rtl/fft_frame_scheduler.sv
// fft_frame_scheduler: feeds 32-beat frames into the 16-lane streaming FFT.
// Upstream beats are accepted on valid/ready and registered one cycle onto
// the FFT input. An upstream underrun zero-fills the rest of the frame, so
// the FFT always receives whole frames. Launches are limited to
// MAX_INFLIGHT frames in the FFT, and frames are separated by MIN_GAP idle
// cycles.
// Optional macro FFT_SCHED_WDOG_EN adds a watchdog. When no output beat is
// seen for WDOG_CYCLES cycles, it drops the in-flight tracking.
module fft_frame_scheduler #(
    parameter int IN_WIDTH     = 9,
    parameter int NUM          = 16,
    parameter int N            = 512,
    parameter int MAX_INFLIGHT = 2,
    parameter int MIN_GAP      = 2,
    parameter int WDOG_CYCLES  = 4096
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enable,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic                                s_sof,
    input  logic [NUM*IN_WIDTH-1:0]             s_din_i,
    input  logic [NUM*IN_WIDTH-1:0]             s_din_q,
    output logic                                fft_valid_in,
    output logic [NUM*IN_WIDTH-1:0]             fft_din_i,
    output logic [NUM*IN_WIDTH-1:0]             fft_din_q,
    input  logic                                fft_valid_out,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]   inflight,
    output logic                                frame_done,
    output logic                                busy,
    output logic                                err_underrun,
    output logic                                err_sof,
    output logic                                err_timeout,
    input  logic                                err_clr
);

    localparam int BEATS = N / NUM;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IFW   = $clog2(MAX_INFLIGHT + 1);
    localparam int GW    = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam int DW    = NUM * IN_WIDTH;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [GW-1:0] LAST_GAP  = GW'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);

    typedef enum logic [1:0] {IDLE, FEED, FLUSH, GAP} state_t;

    // After beat 31 either rest for the gap or go straight back to IDLE
    localparam state_t AFTER_FRAME = (MIN_GAP > 0) ? GAP : IDLE;

    state_t          state_reg, state_next;
    logic [BW-1:0]   beat_cnt_reg, beat_cnt_next;
    logic [GW-1:0]   gap_cnt_reg, gap_cnt_next;
    logic            valid_next, load_data, launch, set_sof, set_underrun;
    logic [DW-1:0]   din_i_next, din_q_next;
    logic            valid_reg;
    logic [DW-1:0]   din_i_reg, din_q_reg;
    logic [BW-1:0]   out_cnt_reg;
    logic [IFW-1:0]  inflight_reg;
    logic            frame_done_reg, err_underrun_reg, err_sof_reg;
    logic            out_beat, complete, wdog_fire;

    // Input-side sequencing: handshake, launch decision, zero-fill and gap
    always_comb begin
        state_next    = state_reg;
        beat_cnt_next = beat_cnt_reg;
        gap_cnt_next  = gap_cnt_reg;
        s_ready       = 1'b0;
        valid_next    = 1'b0;
        load_data     = 1'b0;
        launch        = 1'b0;
        set_sof       = 1'b0;
        set_underrun  = 1'b0;
        case (state_reg)
            IDLE: begin
                s_ready = enable && (inflight_reg < IFW'(MAX_INFLIGHT));
                if (s_valid && s_ready) begin
                    if (s_sof) begin
                        launch        = 1'b1;
                        valid_next    = 1'b1;
                        load_data     = 1'b1;
                        beat_cnt_next = BW'(1);
                        state_next    = FEED;
                    end else begin
                        set_sof = 1'b1;
                    end
                end
            end
            FEED: begin
                s_ready       = 1'b1;
                valid_next    = 1'b1;
                beat_cnt_next = beat_cnt_reg + 1'b1;
                if (s_valid) begin
                    load_data = 1'b1;
                    set_sof   = s_sof;
                end else begin
                    set_underrun = 1'b1;
                end
                if (beat_cnt_reg == LAST_BEAT) begin
                    beat_cnt_next = '0;
                    state_next    = AFTER_FRAME;
                end else if (!s_valid) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                valid_next    = 1'b1;
                beat_cnt_next = beat_cnt_reg + 1'b1;
                if (beat_cnt_reg == LAST_BEAT) begin
                    beat_cnt_next = '0;
                    state_next    = AFTER_FRAME;
                end
            end
            GAP: begin
                if (gap_cnt_reg == LAST_GAP) begin
                    gap_cnt_next = '0;
                    state_next   = IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Per-lane data mux: pass accepted samples, zero on fill or idle beats
    genvar gi;
    generate
        for (gi = 0; gi < NUM; gi++) begin : g_lane
            assign din_i_next[gi*IN_WIDTH +: IN_WIDTH] = load_data ? s_din_i[gi*IN_WIDTH +: IN_WIDTH] : '0;
            assign din_q_next[gi*IN_WIDTH +: IN_WIDTH] = load_data ? s_din_q[gi*IN_WIDTH +: IN_WIDTH] : '0;
        end
    endgenerate

    // Sequencer state and the single registered stage towards the FFT
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            beat_cnt_reg <= '0;
            gap_cnt_reg  <= '0;
            valid_reg    <= 1'b0;
            din_i_reg    <= '0;
            din_q_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            beat_cnt_reg <= beat_cnt_next;
            gap_cnt_reg  <= gap_cnt_next;
            valid_reg    <= valid_next;
            din_i_reg    <= din_i_next;
            din_q_reg    <= din_q_next;
        end
    end

    // Output beats only count while a frame is actually expected
    assign out_beat = fft_valid_out && (inflight_reg != '0);
    assign complete = out_beat && (out_cnt_reg == LAST_BEAT);

    // Output-side tracking: output beat counter, completions, in-flight count
    always_ff @(posedge clk) begin
        if (rst) begin
            out_cnt_reg    <= '0;
            inflight_reg   <= '0;
            frame_done_reg <= 1'b0;
        end else if (wdog_fire) begin
            out_cnt_reg    <= '0;
            inflight_reg   <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= complete;
            if (out_beat) begin
                out_cnt_reg <= complete ? '0 : out_cnt_reg + 1'b1;
            end
            if (launch && !complete) begin
                inflight_reg <= inflight_reg + 1'b1;
            end else if (!launch && complete) begin
                inflight_reg <= inflight_reg - 1'b1;
            end
        end
    end

    // Sticky error flags; a new event in the clear cycle keeps the flag set
    always_ff @(posedge clk) begin
        if (rst) begin
            err_underrun_reg <= 1'b0;
            err_sof_reg      <= 1'b0;
        end else begin
            err_underrun_reg <= set_underrun | (err_underrun_reg & ~err_clr);
            err_sof_reg      <= set_sof | (err_sof_reg & ~err_clr);
        end
    end

`ifdef FFT_SCHED_WDOG_EN
    localparam int WCW = $clog2(WDOG_CYCLES + 1);
    logic [WCW-1:0] wdog_cnt_reg;
    logic           err_timeout_reg;

    assign wdog_fire = (inflight_reg != '0) && !fft_valid_out && (wdog_cnt_reg == WCW'(WDOG_CYCLES - 1));

    // Watchdog: counts silent cycles while frames are outstanding
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt_reg    <= '0;
            err_timeout_reg <= 1'b0;
        end else begin
            if ((inflight_reg == '0) || fft_valid_out || wdog_fire) begin
                wdog_cnt_reg <= '0;
            end else begin
                wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
            end
            err_timeout_reg <= wdog_fire | (err_timeout_reg & ~err_clr);
        end
    end

    assign err_timeout = err_timeout_reg;
`else
    // Constant false: the watchdog is not built
    assign wdog_fire   = (WDOG_CYCLES < 0);
    assign err_timeout = 1'b0;
`endif

    assign fft_valid_in = valid_reg;
    assign fft_din_i    = din_i_reg;
    assign fft_din_q    = din_q_reg;
    assign inflight     = inflight_reg;
    assign frame_done   = frame_done_reg;
    assign busy         = (state_reg != IDLE) || (inflight_reg != '0);
    assign err_underrun = err_underrun_reg;
    assign err_sof      = err_sof_reg;

endmodule
